// File: rtl/gumnut_pkg.sv
// gumnut_pkg: shared types and constants for the Gumnut writeback slice.
//   DATA_W / REG_AW : datapath and register-address widths
//   flags_t         : architectural C/Z/V/N flags
//   wb_entry_t      : one staged ALU result awaiting commit
//   wb_state_t      : writeback stage occupancy
package gumnut_pkg;

   localparam int DATA_W = 8;
   localparam int REG_AW = 3;

   typedef struct packed {
      logic c;
      logic z;
      logic v;
      logic n;
   } flags_t;

   typedef struct packed {
      logic [DATA_W-1:0] res;
      flags_t            flags;
      logic [REG_AW-1:0] rd;
      logic              wr_reg;
      logic              wr_flags;
   } wb_entry_t;

   typedef enum logic {
      WB_IDLE = 1'b0,
      WB_PEND = 1'b1
   } wb_state_t;

   // Forwarded register read: r0 is always zero, a pending write to the
   // same register wins over the (not yet updated) register file.
   function automatic logic [DATA_W-1:0] fwd_read(
      input logic [REG_AW-1:0] addr,
      input logic              pend,
      input wb_entry_t         ent,
      input logic [DATA_W-1:0] rf_data
   );
      logic [DATA_W-1:0] r;
      r = rf_data;
      if (addr == '0)
         r = '0;
      else if (pend && ent.wr_reg && (ent.rd == addr))
         r = ent.res;
      return r;
   endfunction

endpackage

// File: rtl/gumnut_regfile.sv
// gumnut_regfile: 2**REG_AW x DATA_W general register file.
//   clk_i, rst_i          : clock, async active-high reset (clears all regs)
//   we_i, waddr_i, wdata_i: synchronous write port (writes to r0 ignored)
//   raddr_a_i / rdata_a_o : combinational read port A
//   raddr_b_i / rdata_b_o : combinational read port B
module gumnut_regfile #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [REG_AW-1:0] raddr_a_i,
   output logic [DATA_W-1:0] rdata_a_o,
   input  logic [REG_AW-1:0] raddr_b_i,
   output logic [DATA_W-1:0] rdata_b_o
);

   localparam int NREG = 2 ** REG_AW;

   logic [NREG-1:0][DATA_W-1:0] mem_q, mem_d;

   always_comb begin
      mem_d = mem_q;
      if (we_i && (waddr_i != '0))
         mem_d[waddr_i] = wdata_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         mem_q <= '0;
      else
         mem_q <= mem_d;
   end

   // r0 is hardwired to zero on read regardless of storage contents.
   assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
   assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/gumnut_wb_stage.sv
// gumnut_wb_stage: writeback stage behind the Gumnut ALU.
//   valid_i/ready_o/hold_i : accept handshake; hold freezes accept and commit
//   res_i, carry_i, zero_i, ovf_i, nf_i, rd_i, wr_reg_i, wr_flags_i
//                          : ALU result, flags and write controls
//   int_save_i/int_restore_i : flag shadow save / restore pulses
//   rs_addr_i/rs_data_o, rs2_addr_i/rs2_data_o : forwarded read ports
//   carry_o, zero_o, ovf_o, nf_o : forwarded flags
// A result sits in a single stage register for one cycle (longer while
// held) and is committed to the regfile/flags on the following edge.
module gumnut_wb_stage
   import gumnut_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic              hold_i,
   input  logic [DATA_W-1:0] res_i,
   input  logic              carry_i,
   input  logic              zero_i,
   input  logic              ovf_i,
   input  logic              nf_i,
   input  logic [REG_AW-1:0] rd_i,
   input  logic              wr_reg_i,
   input  logic              wr_flags_i,
   input  logic              int_save_i,
   input  logic              int_restore_i,
   input  logic [REG_AW-1:0] rs_addr_i,
   input  logic [REG_AW-1:0] rs2_addr_i,
   output logic [DATA_W-1:0] rs_data_o,
   output logic [DATA_W-1:0] rs2_data_o,
   output logic              carry_o,
   output logic              zero_o,
   output logic              ovf_o,
   output logic              nf_o
);

   wb_state_t state_q, state_d;
   wb_entry_t entry_q, entry_d;
   flags_t    flags_q, flags_d;
   flags_t    shadow_q, shadow_d;

   logic              pend;
   logic              accept;
   logic              commit;
   flags_t            flags_fwd;
   logic [DATA_W-1:0] rf_a, rf_b;

   // ready is forced low during reset so every output reads 0 then.
   assign ready_o = ~hold_i & ~rst_i;
   assign pend    = (state_q == WB_PEND);
   assign accept  = valid_i & ready_o;
   assign commit  = pend & ~hold_i;

   assign flags_fwd = (pend && entry_q.wr_flags) ? entry_q.flags : flags_q;

   always_comb begin
      state_d  = state_q;
      entry_d  = entry_q;
      flags_d  = flags_q;
      shadow_d = shadow_q;

      case (state_q)
         WB_IDLE: if (accept) state_d = WB_PEND;
         WB_PEND: if (!hold_i) state_d = accept ? WB_PEND : WB_IDLE;
         default: state_d = WB_IDLE;
      endcase

      if (accept) begin
         entry_d.res      = res_i;
         entry_d.flags    = '{c: carry_i, z: zero_i, v: ovf_i, n: nf_i};
         entry_d.rd       = rd_i;
         entry_d.wr_reg   = wr_reg_i;
         entry_d.wr_flags = wr_flags_i;
      end

      if (commit && entry_q.wr_flags)
         flags_d = entry_q.flags;

      // Restore overrides a same-edge flag commit and blocks a same-edge save.
      // Save captures the post-commit view, which is exactly flags_fwd.
      if (int_restore_i)
         flags_d = shadow_q;
      else if (int_save_i)
         shadow_d = flags_fwd;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= WB_IDLE;
         entry_q  <= '0;
         flags_q  <= '0;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         entry_q  <= entry_d;
         flags_q  <= flags_d;
         shadow_q <= shadow_d;
      end
   end

   gumnut_regfile #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_rf (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .we_i      (commit & entry_q.wr_reg),
      .waddr_i   (entry_q.rd),
      .wdata_i   (entry_q.res),
      .raddr_a_i (rs_addr_i),
      .rdata_a_o (rf_a),
      .raddr_b_i (rs2_addr_i),
      .rdata_b_o (rf_b)
   );

   assign rs_data_o  = fwd_read(rs_addr_i,  pend, entry_q, rf_a);
   assign rs2_data_o = fwd_read(rs2_addr_i, pend, entry_q, rf_b);

   assign carry_o = flags_fwd.c;
   assign zero_o  = flags_fwd.z;
   assign ovf_o   = flags_fwd.v;
   assign nf_o    = flags_fwd.n;

endmodule

// File: tb/tb_gumnut_wb_stage.sv
// Directed bench for gumnut_wb_stage. Stimulus pushes the expected output
// snapshot for the current cycle into a queue; a monitor drains the queue
// on every falling edge and compares against the live DUT outputs.
module tb_gumnut_wb_stage;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       valid_i, ready_o, hold_i;
   logic [7:0] res_i;
   logic       carry_i, zero_i, ovf_i, nf_i;
   logic [2:0] rd_i;
   logic       wr_reg_i, wr_flags_i, int_save_i, int_restore_i;
   logic [2:0] rs_addr_i, rs2_addr_i;
   logic [7:0] rs_data_o, rs2_data_o;
   logic       carry_o, zero_o, ovf_o, nf_o;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   gumnut_wb_stage dut (
      .clk_i (clk_i), .rst_i (rst_i),
      .valid_i (valid_i), .ready_o (ready_o), .hold_i (hold_i),
      .res_i (res_i), .carry_i (carry_i), .zero_i (zero_i),
      .ovf_i (ovf_i), .nf_i (nf_i), .rd_i (rd_i),
      .wr_reg_i (wr_reg_i), .wr_flags_i (wr_flags_i),
      .int_save_i (int_save_i), .int_restore_i (int_restore_i),
      .rs_addr_i (rs_addr_i), .rs2_addr_i (rs2_addr_i),
      .rs_data_o (rs_data_o), .rs2_data_o (rs2_data_o),
      .carry_o (carry_o), .zero_o (zero_o), .ovf_o (ovf_o), .nf_o (nf_o)
   );

   typedef struct {
      string      nm;
      bit         crs;  logic [7:0] rs;
      bit         crs2; logic [7:0] rs2;
      bit         cfl;  logic [3:0] fl;   // {c,z,v,n}
      bit         crdy; logic       rdy;
   } exp_t;

   exp_t sb[$];

   task automatic push_exp(input string nm,
                           input bit crs,  input logic [7:0] rs,
                           input bit crs2, input logic [7:0] rs2,
                           input bit cfl,  input logic [3:0] fl,
                           input bit crdy, input logic rdy);
      exp_t e;
      e.nm = nm; e.crs = crs; e.rs = rs; e.crs2 = crs2; e.rs2 = rs2;
      e.cfl = cfl; e.fl = fl; e.crdy = crdy; e.rdy = rdy;
      sb.push_back(e);
   endtask

   task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Monitor: checks every snapshot queued for the current cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.crs)  cmp({e.nm, ".rs"},  rs_data_o, e.rs);
            if (e.crs2) cmp({e.nm, ".rs2"}, rs2_data_o, e.rs2);
            if (e.cfl)  cmp({e.nm, ".flags"}, {4'h0, carry_o, zero_o, ovf_o, nf_o}, {4'h0, e.fl});
            if (e.crdy) cmp({e.nm, ".ready"}, {7'h0, ready_o}, {7'h0, e.rdy});
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] r, input logic [2:0] rd,
                        input logic wreg, input logic wfl, input logic [3:0] fl);
      valid_i = v; res_i = r; rd_i = rd; wr_reg_i = wreg; wr_flags_i = wfl;
      {carry_i, zero_i, ovf_i, nf_i} = fl;
   endtask

   initial begin
      rst_i = 1'b1; hold_i = 1'b0; int_save_i = 1'b0; int_restore_i = 1'b0;
      rs_addr_i = 3'd3; rs2_addr_i = 3'd0;
      drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'h0);

      // reset state
      step();
      push_exp("rst", 1, 8'h00, 1, 8'h00, 1, 4'h0, 1, 1'b0);

      // 1: reset while an entry is pending
      step();
      rst_i = 1'b0;
      drive(1'b1, 8'h5A, 3'd3, 1'b1, 1'b0, 4'h0);
      push_exp("t1_pre", 1, 8'h00, 0, 8'h00, 1, 4'h0, 1, 1'b1);
      step();
      drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'h0);
      push_exp("t1_fwd", 1, 8'h5A, 0, 8'h00, 0, 4'h0, 0, 1'b0);
      @(negedge clk_i);
      #1 rst_i = 1'b1;
      step();
      push_exp("t1_inrst", 1, 8'h00, 0, 8'h00, 1, 4'h0, 1, 1'b0);
      step();
      rst_i = 1'b0;
      push_exp("t1_clr", 1, 8'h00, 0, 8'h00, 1, 4'h0, 1, 1'b1);

      // 2: forwarding then committed value
      step();
      rs_addr_i = 3'd2;
      drive(1'b1, 8'h3C, 3'd2, 1'b1, 1'b1, 4'b1000);
      push_exp("t2_pre", 1, 8'h00, 0, 8'h00, 1, 4'h0, 0, 1'b0);
      step();
      drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'h0);
      push_exp("t2_fwd", 1, 8'h3C, 0, 8'h00, 1, 4'b1000, 0, 1'b0);
      step();
      rs2_addr_i = 3'd2;
      push_exp("t2_rf", 1, 8'h3C, 1, 8'h3C, 1, 4'b1000, 0, 1'b0);

      // 3: r0 is never written nor forwarded
      step();
      rs_addr_i = 3'd0; rs2_addr_i = 3'd0;
      drive(1'b1, 8'hFF, 3'd0, 1'b1, 1'b0, 4'h0);
      push_exp("t3_a", 1, 8'h00, 1, 8'h00, 0, 4'h0, 0, 1'b0);
      step();
      drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'h0);
      push_exp("t3_pend", 1, 8'h00, 1, 8'h00, 1, 4'b1000, 0, 1'b0);
      step();
      push_exp("t3_done", 1, 8'h00, 1, 8'h00, 1, 4'b1000, 0, 1'b0);

      // 4: back-to-back with a two-cycle hold
      step();
      rs_addr_i = 3'd1; rs2_addr_i = 3'd1;
      drive(1'b1, 8'h11, 3'd1, 1'b1, 1'b0, 4'h0);
      push_exp("t4_a", 1, 8'h00, 0, 8'h00, 0, 4'h0, 1, 1'b1);
      step();
      drive(1'b1, 8'h22, 3'd1, 1'b1, 1'b0, 4'h0);
      hold_i = 1'b1;
      push_exp("t4_h1", 1, 8'h11, 1, 8'h11, 0, 4'h0, 1, 1'b0);
      step();
      push_exp("t4_h2", 1, 8'h11, 0, 8'h00, 0, 4'h0, 1, 1'b0);
      step();
      hold_i = 1'b0;
      push_exp("t4_rel", 1, 8'h11, 0, 8'h00, 0, 4'h0, 1, 1'b1);
      step();
      drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'h0);
      push_exp("t4_fwd", 1, 8'h22, 1, 8'h22, 0, 4'h0, 0, 1'b0);
      step();
      push_exp("t4_done", 1, 8'h22, 1, 8'h22, 1, 4'b1000, 0, 1'b0);

      // 5: save, overwrite, restore on a commit edge
      step();
      drive(1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 4'b1010);
      step();
      drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'h0);
      int_save_i = 1'b1;
      push_exp("t5_fwd", 0, 8'h00, 0, 8'h00, 1, 4'b1010, 0, 1'b0);
      step();
      int_save_i = 1'b0;
      push_exp("t5_saved", 0, 8'h00, 0, 8'h00, 1, 4'b1010, 0, 1'b0);
      drive(1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 4'b0101);
      step();
      drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'h0);
      step();
      rs_addr_i = 3'd4;
      push_exp("t5_c0z1", 1, 8'h00, 0, 8'h00, 1, 4'b0101, 0, 1'b0);
      drive(1'b1, 8'h77, 3'd4, 1'b1, 1'b1, 4'b0000);
      step();
      drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'h0);
      int_restore_i = 1'b1;
      push_exp("t5_pend", 1, 8'h77, 0, 8'h00, 1, 4'b0000, 0, 1'b0);
      step();
      int_restore_i = 1'b0;
      push_exp("t5_rest", 1, 8'h77, 0, 8'h00, 1, 4'b1010, 0, 1'b0);

      // 6: simultaneous save and restore
      step();
      drive(1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 4'b0000);
      step();
      drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'h0);
      int_save_i = 1'b1;
      push_exp("t6_zero", 0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 1'b0);
      step();
      int_save_i = 1'b0;
      drive(1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 4'b1000);
      step();
      drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'h0);
      push_exp("t6_c1fwd", 0, 8'h00, 0, 8'h00, 1, 4'b1000, 0, 1'b0);
      step();
      int_save_i = 1'b1; int_restore_i = 1'b1;
      push_exp("t6_c1", 0, 8'h00, 0, 8'h00, 1, 4'b1000, 0, 1'b0);
      step();
      int_save_i = 1'b0; int_restore_i = 1'b0;
      push_exp("t6_both", 0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 1'b0);
      drive(1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 4'b1000);
      step();
      drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'h0);
      step();
      int_restore_i = 1'b1;
      push_exp("t6_pre", 0, 8'h00, 0, 8'h00, 1, 4'b1000, 0, 1'b0);
      step();
      int_restore_i = 1'b0;
      push_exp("t6_shadow", 0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 1'b0);

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && sb.size() > 0; i++) step();
      if (sb.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: got %0d pending, expected 0", sb.size());
      end
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
